ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 114 +++++++++++
 tb/tb_ifetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: issues single-outstanding word reads to instruction
// memory and presents one registered instruction at a time to decode/immgen.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_four,
  output logic        instr_vld,
  output logic        misalign_err
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic        req_raw;
  logic        accept;

  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Next-state and request decode; redirect always wins and suppresses requests
  always_comb begin
    state_nxt = state;
    req_raw   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect) begin
          req_raw   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_nxt = imem_rvalid ? IDLE : FLUSH;
        end else if (imem_rvalid) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_nxt = IDLE;
        end else if (!stall) begin
          req_raw   = 1'b1;
          state_nxt = WAIT;
        end
      end
      FLUSH: begin
        if (imem_rvalid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req  = req_raw & ~rst;
  assign imem_addr = fetch_pc;

  // Registered state, fetch pointer and the presented instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      instr        <= NOP_INSTR;
      pc           <= RESET_PC;
      pc_four      <= pc_inc(RESET_PC);
      instr_vld    <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      misalign_err <= redirect & (|redirect_pc[1:0]);
      if (redirect) begin
        fetch_pc  <= word_align(redirect_pc);
        instr_vld <= 1'b0;
      end else if (accept) begin
        instr     <= imem_rdata;
        pc        <= fetch_pc;
        pc_four   <= pc_inc(fetch_pc);
        fetch_pc  <= pc_inc(fetch_pc);
        instr_vld <= 1'b1;
      end else if (req_raw) begin
        // A request out of HOLD means the held instruction was consumed
        instr_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios then randomized traffic, all checked
// cycle by cycle against a transaction-level model of the fetch stream.
module tb_ifetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_four;
  logic        instr_vld;
  logic        misalign_err;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .pc          (pc),
    .pc_four     (pc_four),
    .instr_vld   (instr_vld),
    .misalign_err(misalign_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference view: is a read in flight, is it stale, is an instruction held
  bit          m_out, m_stale, m_hold, m_mis;
  logic [31:0] m_fptr, m_pc, m_instr;

  // Memory model with variable latency and occasional spurious rvalid
  bit          mem_pend;
  int          mem_wait;
  logic [31:0] mem_addr;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          spur_pct = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_stale = 0; m_hold = 0; m_mis = 0;
    m_fptr = RESET_PC; m_pc = RESET_PC; m_instr = 32'h0000_0013;
  endtask

  // One clock cycle: check outputs at negedge, advance model at posedge,
  // then drive the memory response for the following cycle.
  task automatic step();
    logic        exp_req;
    logic        saw_req;
    logic [31:0] saw_addr;
    @(negedge clk);
    exp_req = !rst && !redirect && !m_out && (!m_hold || !stall);
    saw_req = imem_req;
    saw_addr = imem_addr;
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_fptr);
    chk("instr_vld", instr_vld, m_hold);
    chk("pc", pc, m_pc);
    chk("pc_four", pc_four, m_pc + 32'd4);
    chk("instr", instr, m_instr);
    chk("misalign_err", misalign_err, m_mis);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_mis = redirect && (redirect_pc[1:0] != 2'b00);
      if (redirect) begin
        m_fptr = {redirect_pc[31:2], 2'b00};
        m_hold = 0;
        if (m_out && !imem_rvalid) m_stale = 1;
        else m_out = 0;
      end else if (exp_req) begin
        m_out = 1; m_stale = 0; m_hold = 0;
      end else if (m_out && imem_rvalid) begin
        m_out = 0;
        if (!m_stale) begin
          m_hold = 1;
          m_pc = m_fptr;
          m_instr = memf(m_fptr);
          m_fptr = m_fptr + 32'd4;
        end
      end
    end
    if (rst) mem_pend = 0;
    else if (saw_req) begin
      mem_pend = 1;
      mem_addr = saw_addr;
      mem_wait = $urandom_range(lat_hi, lat_lo) - 1;
    end
    #1;
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    if (mem_pend) begin
      if (mem_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata = memf(mem_addr);
        mem_pend = 0;
      end else begin
        mem_wait--;
      end
    end else if (!m_out && ($urandom_range(99, 0) < spur_pct)) begin
      imem_rvalid = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] held_instr, held_pc;
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    imem_rvalid = 0; imem_rdata = 0;
    mem_pend = 0; mem_wait = 0; mem_addr = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    step();
    step();
    chk("reset_instr", instr, 32'h0000_0013);
    chk("reset_vld", instr_vld, 1'b0);

    // First fetch after reset: req in cycle 1, instruction valid in cycle 3
    rst = 0;
    step();
    step();
    chk("first_vld", instr_vld, 1'b1);
    chk("first_pc", pc, 32'h0);
    chk("first_pc_four", pc_four, 32'h4);

    // Stall for five cycles while holding
    stall = 1;
    held_instr = instr;
    held_pc = pc;
    repeat (5) step();
    chk("stall_instr", instr, held_instr);
    chk("stall_pc", pc, held_pc);
    chk("stall_vld", instr_vld, 1'b1);
    stall = 0;
    step();

    // Redirect to 0x100 during WAIT with a 3-cycle response
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20 && !(m_out && !m_stale); i++) step();
    redirect = 1; redirect_pc = 32'h100;
    step();
    redirect = 0;
    for (int i = 0; i < 20 && !instr_vld; i++) step();
    chk("flush_vld", instr_vld, 1'b1);
    chk("flush_pc", pc, 32'h100);

    // Misaligned redirect while holding
    lat_lo = 1; lat_hi = 1;
    stall = 1;
    step();
    redirect = 1; redirect_pc = 32'h102;
    step();
    redirect = 0; stall = 0;
    chk("misalign_pulse", misalign_err, 1'b1);
    step();
    chk("misalign_clear", misalign_err, 1'b0);
    for (int i = 0; i < 20 && !instr_vld; i++) step();
    chk("misalign_pc", pc, 32'h100);

    // Redirect landing on the same cycle as the response
    for (int i = 0; i < 20 && !(imem_rvalid && m_out); i++) step();
    redirect = 1; redirect_pc = 32'h240;
    step();
    redirect = 0;
    for (int i = 0; i < 20 && !instr_vld; i++) step();
    chk("coincide_pc", pc, 32'h240);

    // Wrap of the fetch pointer at the top of the address space
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 0;
    for (int i = 0; i < 20 && !instr_vld; i++) step();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_four", pc_four, 32'h0);
    step();
    for (int i = 0; i < 20 && !instr_vld; i++) step();
    chk("wrap_next_pc", pc, 32'h0);

    // Randomized traffic
    lat_lo = 1; lat_hi = 4; spur_pct = 10;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(99, 0) == 0);
      stall = $urandom_range(1, 0);
      redirect = ($urandom_range(99, 0) < 8);
      redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0))
                                                  : $urandom_range(32'hFFFF, 0);
      step();
    end
    rst = 0; redirect = 0; stall = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
